// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: PC-select encodings and the default boot address.
package fetch_pkg;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_JUMP   = 2'b01;
  localparam logic [1:0] PC_SEL_BRANCH = 2'b10;
  localparam logic [1:0] PC_SEL_TRAP   = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO holding {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign head   = mem[rd_ptr];
  assign do_pop = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stage_fetch_q.sv
// Fetch stage: issues sequential requests under a credit limit, queues in-order responses,
// and redirects on jump/branch/trap while discarding responses that were already in flight.
module stage_fetch_q
  import fetch_pkg::*;
#(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int               QDEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  input  logic [1:0]      pc_selD,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] trap_vector,
  output logic            instr_validF,
  input  logic            instr_readyD,
  output logic [XLEN-1:0] instrF,
  output logic [XLEN-1:0] pcF
);

  localparam int          CW       = $clog2(QDEPTH + 1);
  localparam logic [CW:0] QDEPTH_W = (CW + 1)'(QDEPTH);

  logic [XLEN-1:0]   req_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   target;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     q_count;
  logic              q_empty;
  logic [2*XLEN-1:0] q_head;
  logic              redirect;
  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              pop;

  assign redirect = (pc_selD != PC_SEL_SEQ);

  // Requests in flight plus queued entries never exceed QDEPTH, so every response has a slot.
  assign credit_ok = ({1'b0, outstanding} + {1'b0, q_count}) < QDEPTH_W;
  assign req_valid = rst_n && !redirect && credit_ok;
  assign req_addr  = req_pc;
  assign accept    = req_valid && req_ready;

  assign push         = resp_valid && !redirect && (drop_cnt == '0);
  assign instr_validF = !q_empty;
  assign pop          = instr_validF && instr_readyD;
  assign {pcF, instrF} = q_head;

  always_comb begin
    target = jump_target;
    unique case (pc_selD)
      PC_SEL_JUMP:   target = jump_target;
      PC_SEL_BRANCH: target = branch_target;
      PC_SEL_TRAP:   target = trap_vector;
      default:       target = jump_target;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc  <= RESET_PC;
      resp_pc <= RESET_PC;
    end else if (redirect) begin
      req_pc  <= target;
      resp_pc <= target;
    end else begin
      if (accept) req_pc  <= req_pc + XLEN'(4);
      if (push)   resp_pc <= resp_pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, resp_valid})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Everything still in flight after a redirect belongs to the old path and is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (redirect) begin
      drop_cnt <= outstanding - CW'(resp_valid);
    end else if (resp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .W     (2 * XLEN),
    .DEPTH (QDEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({resp_pc, resp_data}),
    .pop       (pop),
    .flush     (redirect),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  a_resp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (outstanding != '0));

  a_req_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    req_valid |-> (req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_stage_fetch_q.sv
// Directed bench for stage_fetch_q: in-order memory model, expected-queue scoreboard, pop monitor.
module tb_stage_fetch_q;
  import fetch_pkg::*;

  localparam int XLEN   = 32;
  localparam int QDEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_valid;
  logic            req_ready = 1'b0;
  logic [XLEN-1:0] req_addr;
  logic            resp_valid = 1'b0;
  logic [XLEN-1:0] resp_data = '0;
  logic [1:0]      pc_selD = PC_SEL_SEQ;
  logic [XLEN-1:0] jump_target = '0;
  logic [XLEN-1:0] branch_target = '0;
  logic [XLEN-1:0] trap_vector = '0;
  logic            instr_validF;
  logic            instr_readyD = 1'b1;
  logic [XLEN-1:0] instrF;
  logic [XLEN-1:0] pcF;

  always #5 clk = ~clk;

  stage_fetch_q #(
    .XLEN     (XLEN),
    .RESET_PC (32'h4000_0000),
    .QDEPTH   (QDEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .pc_selD       (pc_selD),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .trap_vector   (trap_vector),
    .instr_validF  (instr_validF),
    .instr_readyD  (instr_readyD),
    .instrF        (instrF),
    .pcF           (pcF)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*XLEN-1:0] exp_q[$];
  logic [XLEN-1:0]   exp_addr_q[$];
  logic [XLEN-1:0]   pend_q[$];
  int                budget   = 0;
  bit                mem_hold = 1'b0;
  int                n_accept = 0;

  function automatic logic [XLEN-1:0] mem_fn(input logic [XLEN-1:0] a);
    return (a ^ 32'hC0DE_0000) + 32'h0000_0013;
  endfunction

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [XLEN-1:0] pc);
    exp_addr_q.push_back(pc);
    exp_q.push_back({pc, mem_fn(pc)});
  endtask

  task automatic expect_req_only(input logic [XLEN-1:0] pc);
    exp_addr_q.push_back(pc);
  endtask

  // Memory model: answers each accepted request on the following cycle unless held.
  task automatic drive_and_sample();
    resp_valid = 1'b0;
    resp_data  = '0;
    if (!mem_hold && pend_q.size() > 0) begin
      resp_valid = 1'b1;
      resp_data  = mem_fn(pend_q.pop_front());
    end
    req_ready = (budget > 0);
    #1;
    if (pc_selD != PC_SEL_SEQ) check("no_req_on_redirect", XLEN'(req_valid), '0);
    if (req_valid && req_ready) begin
      budget--;
      n_accept++;
      pend_q.push_back(req_addr);
      if (exp_addr_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_req: got addr %h expected no request", req_addr);
      end else begin
        check("req_addr", req_addr, exp_addr_q.pop_front());
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive_and_sample();
  endtask

  task automatic drain(input int max_cycles);
    int i = 0;
    while ((exp_q.size() != 0 || pend_q.size() != 0) && i < max_cycles) begin
      cycle();
      i++;
    end
    cycle();
    check("drain_left", XLEN'(exp_q.size()), '0);
  endtask

  // Monitor: every accepted pop must match the head of the expected queue.
  initial begin
    logic [2*XLEN-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && instr_validF && instr_readyD && pc_selD == PC_SEL_SEQ) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got pc %h expected none", pcF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", pcF, e[2*XLEN-1:XLEN]);
          check("pop_instr", instrF, e[XLEN-1:0]);
        end
      end
    end
  end

  initial begin
    // Reset values
    #1;
    check("rst_req_valid", XLEN'(req_valid), '0);
    check("rst_instr_validF", XLEN'(instr_validF), '0);
    check("rst_instrF", instrF, '0);
    check("rst_pcF", pcF, '0);
    repeat (2) cycle();

    // 1: sequential fetch from the reset PC, first instruction visible on cycle 3
    budget = 4;
    for (int i = 0; i < 4; i++) expect_fetch(32'h4000_0000 + 32'(4 * i));
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_sample();
    check("t1_valid_c1", XLEN'(instr_validF), '0);
    cycle();
    check("t1_valid_c2", XLEN'(instr_validF), '0);
    cycle();
    check("t1_valid_c3", XLEN'(instr_validF), 32'd1);
    drain(50);

    // 2: decode stalled -> only QDEPTH requests accepted, then resume
    instr_readyD = 1'b0;
    budget = 10;
    n_accept = 0;
    for (int i = 0; i < 10; i++) expect_fetch(32'h4000_0010 + 32'(4 * i));
    repeat (10) cycle();
    check("t2_accepts_stalled", XLEN'(n_accept), 32'd4);
    check("t2_req_valid_stalled", XLEN'(req_valid), '0);
    check("t2_head_valid", XLEN'(instr_validF), 32'd1);
    instr_readyD = 1'b1;
    drain(100);
    check("t2_accepts_total", XLEN'(n_accept), 32'd10);

    // 3: jump with two requests in flight -> both responses dropped
    mem_hold = 1'b1;
    budget = 2;
    expect_req_only(32'h4000_0038);
    expect_req_only(32'h4000_003C);
    repeat (3) cycle();
    pc_selD = PC_SEL_JUMP;
    jump_target = 32'h4000_0100;
    cycle();
    pc_selD = PC_SEL_SEQ;
    mem_hold = 1'b0;
    budget = 3;
    for (int i = 0; i < 3; i++) expect_fetch(32'h4000_0100 + 32'(4 * i));
    drain(50);

    // 4: trap in the same cycle as a response -> response dropped, queue empty
    mem_hold = 1'b1;
    budget = 1;
    expect_req_only(32'h4000_010C);
    repeat (2) cycle();
    pc_selD = PC_SEL_TRAP;
    trap_vector = 32'h1000_0000;
    mem_hold = 1'b0;
    cycle();
    check("t4_resp_in_redirect", XLEN'(resp_valid), 32'd1);
    pc_selD = PC_SEL_SEQ;
    cycle();
    check("t4_queue_empty", XLEN'(instr_validF), '0);
    check("t4_req_addr", req_addr, 32'h1000_0000);
    check("t4_req_valid", XLEN'(req_valid), 32'd1);
    budget = 2;
    expect_fetch(32'h1000_0000);
    expect_fetch(32'h1000_0004);
    drain(50);

    // 5: branch then jump on consecutive cycles -> only jump path reaches decode
    mem_hold = 1'b1;
    budget = 2;
    expect_req_only(32'h1000_0008);
    expect_req_only(32'h1000_000C);
    repeat (3) cycle();
    pc_selD = PC_SEL_BRANCH;
    branch_target = 32'h2000_0000;
    cycle();
    pc_selD = PC_SEL_JUMP;
    jump_target = 32'h3000_0000;
    mem_hold = 1'b0;
    cycle();
    pc_selD = PC_SEL_SEQ;
    budget = 3;
    for (int i = 0; i < 3; i++) expect_fetch(32'h3000_0000 + 32'(4 * i));
    drain(50);
    repeat (3) cycle();
    check("t5_outstanding", XLEN'(dut.outstanding), '0);
    check("t5_drop_cnt", XLEN'(dut.drop_cnt), '0);

    // 6: asynchronous reset mid-stream, then restart at the reset PC
    budget = 5;
    for (int i = 0; i < 5; i++) expect_fetch(32'h3000_000C + 32'(4 * i));
    repeat (3) cycle();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_req_valid", XLEN'(req_valid), '0);
    check("t6_instr_validF", XLEN'(instr_validF), '0);
    check("t6_instrF", instrF, '0);
    check("t6_pcF", pcF, '0);
    exp_q.delete();
    exp_addr_q.delete();
    pend_q.delete();
    budget = 0;
    repeat (2) cycle();
    budget = 3;
    for (int i = 0; i < 3; i++) expect_fetch(32'h4000_0000 + 32'(4 * i));
    @(negedge clk);
    rst_n = 1'b1;
    drive_and_sample();
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
